// File: rtl/snic_loader_pkg.sv
// Shared types and constants for the SNIC IMEM loader: FSM states,
// AXI-Lite response codes, the write request struct and the boot
// address derivation.
package snic_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLR_WR,
        CLR_RESP,
        IMG_WAIT,
        IMG_WR,
        IMG_RESP,
        SET_WR,
        SET_RESP,
        FIN
    } loader_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_req_t;

    // The boot control word lives in the last word of the IMEM span.
    function automatic logic [31:0] boot_addr(input logic [31:0] base,
                                              input logic [31:0] size);
        return base + size - 32'd4;
    endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI-Lite write channel bundle (AW/W/B) with initiator and responder views.
interface taxi_axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport wr_mst (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport wr_slv (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/snic_axil_wr_single.sv
// One AXI-Lite write at a time. The first cycle of wr_phase launches AW and W
// together from a latched copy of req; each valid drops on its own handshake.
// bready follows resp_phase so the sequencing FSM owns when B is accepted.
module snic_axil_wr_single
    import snic_loader_pkg::*;
(
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        wr_phase,
    input  logic        resp_phase,
    input  wr_req_t     req,
    output logic        addr_data_done,
    output logic        resp_done,
    output logic [1:0]  resp_code,
    taxi_axil_if.wr_mst axil
);
    logic    launched;
    logic    awvalid_q;
    logic    wvalid_q;
    wr_req_t req_q;

    // Launch on entry to a write phase, then retire AW and W independently.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            launched  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            req_q     <= '0;
        end else if (wr_phase && !launched) begin
            launched  <= 1'b1;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            req_q     <= req;
        end else begin
            if (awvalid_q && axil.awready) awvalid_q <= 1'b0;
            if (wvalid_q && axil.wready)   wvalid_q  <= 1'b0;
            if (resp_done)                 launched  <= 1'b0;
        end
    end

    // Both channels are done once each valid is low or handshaking now.
    assign addr_data_done = launched && (!awvalid_q || axil.awready)
                                     && (!wvalid_q  || axil.wready);
    assign resp_done = resp_phase && axil.bvalid;
    assign resp_code = axil.bresp;

    assign axil.awaddr  = req_q.addr;
    assign axil.awprot  = 3'b000;
    assign axil.awvalid = awvalid_q;
    assign axil.wdata   = req_q.data;
    assign axil.wstrb   = '1;
    assign axil.wvalid  = wvalid_q;
    assign axil.bready  = resp_phase;

endmodule

// File: rtl/snic_imem_loader.sv
// Streams a firmware image into IMEM over AXI-Lite. The boot word is cleared
// first so the core stays in reset during the load; each accepted stream word
// becomes one write at consecutive word addresses.
// Build option SNIC_LOADER_AUTOBOOT_EN: when defined, a clean load finishes by
// writing 1 to the boot word; otherwise done is raised after the last image
// word and the host releases the core itself.
module snic_imem_loader
    import snic_loader_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE       = 32'h0000_0000,
    parameter logic [31:0] IMEM_SIZE_BYTES = 32'h0001_0000,
    parameter int          MAX_OUTSTANDING = 1
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        start,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    taxi_axil_if.wr_mst m_axil_wr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [14:0] word_count
);
    localparam logic [31:0] BOOT_ADDR = boot_addr(IMEM_BASE, IMEM_SIZE_BYTES);

    if (MAX_OUTSTANDING != 1) begin : g_cfg_check
        $error("snic_imem_loader supports exactly one outstanding write");
    end

    loader_state_t state, state_n;
    logic [31:0]   img_addr;
    logic [31:0]   word_q;
    logic          last_q;
    logic          wr_phase, resp_phase;
    logic          addr_data_done, resp_done;
    logic [1:0]    resp_code;
    wr_req_t       req;
    logic          resp_ok;

    assign resp_ok = (resp_code == RESP_OKAY);

    snic_axil_wr_single u_wr (
        .core_clk       (core_clk),
        .core_rst_n     (core_rst_n),
        .wr_phase       (wr_phase),
        .resp_phase     (resp_phase),
        .req            (req),
        .addr_data_done (addr_data_done),
        .resp_done      (resp_done),
        .resp_code      (resp_code),
        .axil           (m_axil_wr)
    );

    // State register.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) state <= IDLE;
        else             state <= state_n;
    end

    // Next state and per-state write request / phase strobes.
    always_comb begin
        state_n    = state;
        wr_phase   = 1'b0;
        resp_phase = 1'b0;
        req        = '0;
        case (state)
            IDLE:     if (start) state_n = CLR_WR;
            CLR_WR: begin
                wr_phase = 1'b1;
                req      = '{addr: BOOT_ADDR, data: 32'h0};
                if (addr_data_done) state_n = CLR_RESP;
            end
            CLR_RESP: begin
                resp_phase = 1'b1;
                if (resp_done) state_n = resp_ok ? IMG_WAIT : FIN;
            end
            // An image that would reach the boot word is an overflow.
            IMG_WAIT: if (s_tvalid) state_n = (img_addr == BOOT_ADDR) ? FIN : IMG_WR;
            IMG_WR: begin
                wr_phase = 1'b1;
                req      = '{addr: img_addr, data: word_q};
                if (addr_data_done) state_n = IMG_RESP;
            end
            IMG_RESP: begin
                resp_phase = 1'b1;
                if (resp_done) begin
                    if (!resp_ok)    state_n = FIN;
`ifdef SNIC_LOADER_AUTOBOOT_EN
                    else if (last_q) state_n = SET_WR;
`else
                    else if (last_q) state_n = FIN;
`endif
                    else             state_n = IMG_WAIT;
                end
            end
`ifdef SNIC_LOADER_AUTOBOOT_EN
            SET_WR: begin
                wr_phase = 1'b1;
                req      = '{addr: BOOT_ADDR, data: 32'h1};
                if (addr_data_done) state_n = SET_RESP;
            end
            SET_RESP: begin
                resp_phase = 1'b1;
                if (resp_done) state_n = FIN;
            end
`endif
            FIN:      state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Image address, captured word, counters and sticky status.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            img_addr   <= IMEM_BASE;
            word_q     <= '0;
            last_q     <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    img_addr   <= IMEM_BASE;
                    done       <= 1'b0;
                    error      <= 1'b0;
                    word_count <= '0;
                end
                CLR_RESP: if (resp_done && !resp_ok) error <= 1'b1;
                IMG_WAIT: if (s_tvalid) begin
                    if (img_addr == BOOT_ADDR) error <= 1'b1;
                    else begin
                        word_q <= s_tdata;
                        last_q <= s_tlast;
                    end
                end
                IMG_RESP: if (resp_done) begin
                    if (resp_ok) begin
                        img_addr   <= img_addr + 32'd4;
                        word_count <= word_count + 15'd1;
`ifndef SNIC_LOADER_AUTOBOOT_EN
                        if (last_q) done <= 1'b1;
`endif
                    end else begin
                        error <= 1'b1;
                    end
                end
`ifdef SNIC_LOADER_AUTOBOOT_EN
                SET_RESP: if (resp_done) begin
                    if (resp_ok) done  <= 1'b1;
                    else         error <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign s_tready = (state == IMG_WAIT);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_snic_imem_loader.sv
// Directed bench for snic_imem_loader with a small AXI-Lite write responder
// (programmable AW stall, SLVERR on a chosen address) and a log of completed
// writes.
module tb_snic_imem_loader;

    logic        core_clk   = 1'b0;
    logic        core_rst_n = 1'b0;
    logic        start      = 1'b0;
    logic [31:0] s_tdata    = '0;
    logic        s_tvalid   = 1'b0;
    logic        s_tlast    = 1'b0;
    logic        s_tready, busy, done, error;
    logic [14:0] word_count;

    int n_tests = 0;
    int n_fail  = 0;

    taxi_axil_if axil ();

    snic_imem_loader dut (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .start      (start),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .m_axil_wr  (axil),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 core_clk = ~core_clk;

    // Responder: awready held low for aw_delay cycles, wready immediate.
    int          aw_delay = 0;
    logic [31:0] err_addr = 32'h1;
    logic        aw_got, w_got, bvalid_r;
    logic [1:0]  bresp_r;
    logic [31:0] aw_addr_q, w_data_q;
    int          aw_cnt;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    assign axil.awready = !aw_got && (aw_cnt >= aw_delay);
    assign axil.wready  = !w_got;
    assign axil.bvalid  = bvalid_r;
    assign axil.bresp   = bresp_r;

    always @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0; bresp_r <= 2'b00;
            aw_cnt <= 0; aw_addr_q <= '0; w_data_q <= '0;
        end else begin
            if (axil.awvalid && axil.awready) begin
                aw_got    <= 1'b1;
                aw_addr_q <= axil.awaddr;
            end else if (axil.awvalid && !aw_got) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (axil.wvalid && axil.wready) begin
                w_got    <= 1'b1;
                w_data_q <= axil.wdata;
            end
            if (!bvalid_r && (aw_got || (axil.awvalid && axil.awready))
                          && (w_got  || (axil.wvalid  && axil.wready))) begin
                bvalid_r <= 1'b1;
                bresp_r  <= (((aw_got ? aw_addr_q : axil.awaddr) == err_addr) ? 2'b10 : 2'b00);
            end
            if (bvalid_r && axil.bready) begin
                bvalid_r <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0;
                log_addr.push_back(aw_addr_q);
                log_data.push_back(w_data_q);
            end
        end
    end

    // Protocol watch: stable awaddr during AW stall, full strobes, awprot zero.
    logic        aw_hold = 1'b0, aw_unstable = 1'b0, bad_strb = 1'b0, bad_prot = 1'b0;
    logic [31:0] aw_prev = '0;
    always @(posedge core_clk) begin
        if (axil.awvalid && !axil.awready) begin
            if (aw_hold && axil.awaddr != aw_prev) aw_unstable <= 1'b1;
            aw_hold <= 1'b1;
            aw_prev <= axil.awaddr;
        end else begin
            aw_hold <= 1'b0;
        end
        if (axil.wvalid && axil.wstrb != 4'hF) bad_strb <= 1'b1;
        if (axil.awvalid && axil.awprot != 3'b000) bad_prot <= 1'b1;
    end

    task automatic pulse_start;
        @(negedge core_clk); start = 1'b1;
        @(negedge core_clk); start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, output bit ok);
        ok = 1'b0;
        @(negedge core_clk);
        s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
        for (int i = 0; i < 200; i++) begin
            if (s_tready) begin
                @(posedge core_clk);
                ok = 1'b1;
                break;
            end
            @(negedge core_clk);
        end
        #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge core_clk);
            if (!busy) begin seen = 1'b1; break; end
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL idle_timeout: busy=%0b required 0", busy); end
    endtask

    task automatic test_reset;
        bit quiet = 1'b1;
        #12;
        n_tests++;
        if ({busy, done, error, s_tready, axil.awvalid, axil.wvalid, axil.bready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {busy, done, error, s_tready, axil.awvalid, axil.wvalid, axil.bready});
        end
        n_tests++;
        if (word_count !== 15'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d required 0", word_count); end
        @(negedge core_clk); core_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            if (axil.awvalid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin n_fail++; $display("FAIL post_reset_quiet: activity without start"); end
    endtask

    task automatic test_basic_load;
        int base, en, nacc;
        bit ok;
        logic [31:0] ea[5];
        logic [31:0] ed[5];
        ea = '{32'hFFFC, 32'h0, 32'h4, 32'h8, 32'hFFFC};
        ed = '{32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h1};
`ifdef SNIC_LOADER_AUTOBOOT_EN
        en = 5;
`else
        en = 4;
`endif
        base = log_addr.size(); nacc = 0;
        pulse_start();
        send_word(32'h11111111, 1'b0, ok); nacc += int'(ok);
        send_word(32'h22222222, 1'b0, ok); nacc += int'(ok);
        send_word(32'h33333333, 1'b1, ok); nacc += int'(ok);
        wait_idle(200);
        n_tests++;
        if (nacc !== 3) begin n_fail++; $display("FAIL basic_accepted: got %0d required 3", nacc); end
        n_tests++;
        if (log_addr.size() - base !== en) begin
            n_fail++; $display("FAIL basic_write_count: got %0d required %0d", log_addr.size() - base, en);
        end
        for (int i = 0; i < en; i++) begin
            if (base + i < log_addr.size()) begin
                n_tests++;
                if ({log_addr[base+i], log_data[base+i]} !== {ea[i], ed[i]}) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: got %h<-%h required %h<-%h",
                             i, log_addr[base+i], log_data[base+i], ea[i], ed[i]);
                end
            end
        end
        n_tests++;
        if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL basic_status: done,error=%b required 10", {done, error}); end
        n_tests++;
        if (word_count !== 15'd3) begin n_fail++; $display("FAIL basic_word_count: got %0d required 3", word_count); end
        n_tests++;
        if ({bad_strb, bad_prot} !== 2'b00) begin n_fail++; $display("FAIL basic_strb_prot: flags=%b required 00", {bad_strb, bad_prot}); end
    endtask

    task automatic test_start_rules;
        bit ok, fin_seen = 1'b0, stayed_idle = 1'b1;
        pulse_start();
        send_word(32'h5A5A0001, 1'b1, ok);
        for (int i = 0; i < 200; i++) begin
            @(negedge core_clk);
            if (busy && (done || error)) begin fin_seen = 1'b1; break; end
        end
        n_tests++;
        if (!fin_seen) begin n_fail++; $display("FAIL fin_seen: FIN cycle not observed"); end
        start = 1'b1;
        @(negedge core_clk); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (busy !== 1'b0) stayed_idle = 1'b0;
            @(negedge core_clk);
        end
        n_tests++;
        if (!stayed_idle) begin n_fail++; $display("FAIL start_at_fin: busy rose, required ignored start"); end
        n_tests++;
        if ({done, word_count} !== {1'b1, 15'd1}) begin
            n_fail++; $display("FAIL start_at_fin_status: done=%b wc=%0d required 1/1", done, word_count);
        end
        pulse_start();
        n_tests++;
        if ({busy, done, error, word_count} !== {3'b100, 15'd0}) begin
            n_fail++; $display("FAIL restart_clear: busy,done,error=%b wc=%0d required 100/0",
                               {busy, done, error}, word_count);
        end
        send_word(32'h5A5A0002, 1'b1, ok);
        wait_idle(200);
    endtask

    task automatic test_aw_stall;
        int base, en;
        bit ok, seen = 1'b0, held = 1'b1;
`ifdef SNIC_LOADER_AUTOBOOT_EN
        en = 3;
`else
        en = 2;
`endif
        aw_delay = 5;
        base = log_addr.size();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (axil.awvalid) begin seen = 1'b1; break; end
            @(negedge core_clk);
        end
        n_tests++;
        if (!(seen && axil.wvalid === 1'b1)) begin
            n_fail++; $display("FAIL stall_launch: awvalid=%b wvalid=%b required 1/1", axil.awvalid, axil.wvalid);
        end
        @(negedge core_clk);
        n_tests++;
        if ({axil.awvalid, axil.wvalid, axil.awaddr} !== {2'b10, 32'hFFFC}) begin
            n_fail++; $display("FAIL stall_w_drop: aw,w=%b addr=%h required 10/0000fffc",
                               {axil.awvalid, axil.wvalid}, axil.awaddr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge core_clk);
            if (axil.awvalid !== 1'b1 || axil.awaddr !== 32'hFFFC) held = 1'b0;
        end
        n_tests++;
        if (!held) begin n_fail++; $display("FAIL stall_aw_hold: awvalid dropped or awaddr moved"); end
        send_word(32'hCAFE0000, 1'b1, ok);
        wait_idle(400);
        aw_delay = 0;
        n_tests++;
        if (log_addr.size() - base !== en) begin
            n_fail++; $display("FAIL stall_write_count: got %0d required %0d", log_addr.size() - base, en);
        end
        if (log_addr.size() > base) begin
            n_tests++;
            if ({log_addr[base], log_data[base]} !== {32'hFFFC, 32'h0}) begin
                n_fail++; $display("FAIL stall_clear_write: got %h<-%h required 0000fffc<-0", log_addr[base], log_data[base]);
            end
        end
        n_tests++;
        if (aw_unstable !== 1'b0) begin n_fail++; $display("FAIL stall_addr_stable: awaddr changed while stalled"); end
    endtask

    task automatic test_bresp_err;
        int base;
        bit ok, boot_seen = 1'b0;
        err_addr = 32'h4;
        base = log_addr.size();
        pulse_start();
        send_word(32'hE0000000, 1'b0, ok);
        send_word(32'hE0000001, 1'b0, ok);
        wait_idle(200);
        err_addr = 32'h1;
        for (int i = base; i < log_addr.size(); i++)
            if (log_addr[i] == 32'hFFFC && log_data[i] == 32'h1) boot_seen = 1'b1;
        n_tests++;
        if ({done, error} !== 2'b01) begin n_fail++; $display("FAIL bresp_status: done,error=%b required 01", {done, error}); end
        n_tests++;
        if (word_count !== 15'd1) begin n_fail++; $display("FAIL bresp_word_count: got %0d required 1", word_count); end
        n_tests++;
        if (log_addr.size() - base !== 3) begin
            n_fail++; $display("FAIL bresp_write_count: got %0d required 3", log_addr.size() - base);
        end
        n_tests++;
        if (boot_seen) begin n_fail++; $display("FAIL bresp_no_boot: boot write seen, required none"); end
    endtask

    task automatic test_reset_mid;
        int base;
        bit ok, seen = 1'b0;
        aw_delay = 3;
        pulse_start();
        send_word(32'hA0000000, 1'b0, ok);
        send_word(32'hA0000001, 1'b0, ok);
        for (int i = 0; i < 40; i++) begin
            @(negedge core_clk);
            if (axil.awvalid && axil.awaddr == 32'h4) begin seen = 1'b1; break; end
        end
        n_tests++;
        if (!(seen && word_count === 15'd1)) begin
            n_fail++; $display("FAIL mid_setup: awvalid@4 seen=%b wc=%0d required 1/1", seen, word_count);
        end
        #2 core_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, error, s_tready, axil.awvalid, axil.wvalid, axil.bready, word_count} !== 22'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: flags=%b wc=%0d required 0/0",
                               {busy, done, error, s_tready, axil.awvalid, axil.wvalid, axil.bready}, word_count);
        end
        @(negedge core_clk); core_rst_n = 1'b1;
        aw_delay = 0;
        base = log_addr.size();
        pulse_start();
        n_tests++;
        if ({busy, word_count} !== {1'b1, 15'd0}) begin
            n_fail++; $display("FAIL mid_restart: busy=%b wc=%0d required 1/0", busy, word_count);
        end
        send_word(32'hB0000000, 1'b1, ok);
        wait_idle(200);
        n_tests++;
        if (log_addr.size() - base < 2 ||
            {log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]}
                !== {32'hFFFC, 32'h0, 32'h0, 32'hB0000000}) begin
            n_fail++; $display("FAIL mid_restart_writes: %0d writes, required clear then 0<-b0000000",
                               log_addr.size() - base);
        end
        n_tests++;
        if ({done, word_count} !== {1'b1, 15'd1}) begin
            n_fail++; $display("FAIL mid_restart_done: done=%b wc=%0d required 1/1", done, word_count);
        end
    endtask

    task automatic test_overflow;
        int base, nacc = 0, n;
        bit ok, boot_seen = 1'b0;
        base = log_addr.size();
        pulse_start();
        for (int i = 0; i < 16383; i++) begin
            send_word(32'hC0000000 | i, 1'b0, ok);
            nacc += int'(ok);
        end
        send_word(32'hC0003FFF, 1'b1, ok);
        wait_idle(200);
        n = log_addr.size() - base;
        for (int i = base; i < log_addr.size(); i++)
            if (log_addr[i] == 32'hFFFC && log_data[i] == 32'h1) boot_seen = 1'b1;
        n_tests++;
        if (nacc !== 16383 || ok !== 1'b1) begin
            n_fail++; $display("FAIL ovf_accepted: got %0d+%0b required 16383+1", nacc, ok);
        end
        n_tests++;
        if (n !== 16384) begin n_fail++; $display("FAIL ovf_write_count: got %0d required 16384", n); end
        if (n > 0) begin
            n_tests++;
            if ({log_addr[base+n-1], log_data[base+n-1]} !== {32'hFFF8, 32'hC0003FFE}) begin
                n_fail++; $display("FAIL ovf_last_write: got %h<-%h required 0000fff8<-c0003ffe",
                                   log_addr[base+n-1], log_data[base+n-1]);
            end
        end
        n_tests++;
        if ({done, error, word_count} !== {2'b01, 15'd16383}) begin
            n_fail++; $display("FAIL ovf_status: done,error=%b wc=%0d required 01/16383", {done, error}, word_count);
        end
        n_tests++;
        if (boot_seen) begin n_fail++; $display("FAIL ovf_no_boot: boot write seen, required none"); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_start_rules();
        test_aw_stall();
        test_bresp_err();
        test_reset_mid();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
